// File: rtl/char_buffer_fill.sv
// rtl/char_buffer_fill.sv - rectangular-span fill engine for the character buffer write port
// Walks a raster-ordered cell range and writes a constant or incrementing code per cell.
module char_buffer_fill #(
  parameter int COLS   = 80,
  parameter int ROWS   = 32,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5,
  parameter int DATA_W = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   seq,
  input  logic [DATA_W-1:0]      fill_char,
  input  logic [ROW_W-1:0]       start_row,
  input  logic [COL_W-1:0]       start_col,
  input  logic [ROW_W-1:0]       end_row,
  input  logic [COL_W-1:0]       end_col,
  input  logic                   abort,
  input  logic                   wr_ready,
  output logic                   wr_en,
  output logic [COL_W+ROW_W-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int ADDR_W = COL_W + ROW_W;

  typedef enum logic {IDLE, ACTIVE} stateT;

  stateT            state, nextState;
  logic [ROW_W-1:0] endRowR;
  logic [COL_W-1:0] endColR;
  logic             seqR;

  logic [COL_W-1:0] curCol;
  logic [ROW_W-1:0] curRow;
  logic [31:0]      startLin, endLin;
  logic             reqValid, load, accept, atEnd, doneNext, errNext;

  // The write address register doubles as the traversal cursor.
  assign curCol = wr_addr[ADDR_W-1:ROW_W];
  assign curRow = wr_addr[ROW_W-1:0];

  assign busy  = (state == ACTIVE);
  assign wr_en = busy;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    load      = 1'b0;
    startLin  = 32'(start_row) * 32'(COLS) + 32'(start_col);
    endLin    = 32'(end_row) * 32'(COLS) + 32'(end_col);
    reqValid  = (32'(start_row) < 32'(ROWS)) && (32'(end_row) < 32'(ROWS)) &&
                (32'(start_col) < 32'(COLS)) && (32'(end_col) < 32'(COLS)) &&
                (endLin >= startLin);
    accept    = (state == ACTIVE) && wr_ready;
    atEnd     = (curRow == endRowR) && (curCol == endColR);
    case (state)
      IDLE: begin
        if (start) begin
          if (reqValid) begin
            load      = 1'b1;
            nextState = ACTIVE;
          end else begin
            errNext = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // abort wins over completion of the last cell
        if (abort) begin
          nextState = IDLE;
        end else if (accept && atEnd) begin
          nextState = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr <= '0;
      wr_data <= '0;
      endRowR <= '0;
      endColR <= '0;
      seqR    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= doneNext;
      err  <= errNext;
      if (load) begin
        wr_addr <= {start_col, start_row};
        wr_data <= fill_char;
        endRowR <= end_row;
        endColR <= end_col;
        seqR    <= seq;
      end else if (accept && !atEnd) begin
        // the cursor parks on the final cell so IDLE shows the last write
        if (curCol == COL_W'(COLS - 1)) begin
          wr_addr <= {{COL_W{1'b0}}, curRow + ROW_W'(1)};
        end else begin
          wr_addr <= {curCol + COL_W'(1), curRow};
        end
        if (seqR) wr_data <= wr_data + DATA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_char_buffer_fill.sv
// tb/tb_char_buffer_fill.sv - directed bench for char_buffer_fill
module tb_char_buffer_fill;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        seq = 1'b0;
  logic [6:0]  fill_char = '0;
  logic [4:0]  start_row = '0;
  logic [6:0]  start_col = '0;
  logic [4:0]  end_row = '0;
  logic [6:0]  end_col = '0;
  logic        abort = 1'b0;
  logic        wr_ready = 1'b0;
  logic        wr_en, busy, done, err;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;

  int total = 0;
  int bad = 0;

  logic [11:0] wAddr [0:2599];
  logic [6:0]  wData [0:2599];
  logic [11:0] cAddr [0:2599];
  logic [6:0]  cData [0:2599];

  char_buffer_fill dut (
    .clk(clk), .reset(reset), .start(start), .seq(seq), .fill_char(fill_char),
    .start_row(start_row), .start_col(start_col), .end_row(end_row), .end_col(end_col),
    .abort(abort), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mkAddr(input int col, input int row);
    logic [6:0] c;
    logic [4:0] r;
    c = 7'(col);
    r = 5'(row);
    return {c, r};
  endfunction

  task automatic request(input logic s, input logic [6:0] fc, input int sr, input int sc,
                         input int er, input int ec, input logic ab);
    seq = s; fill_char = fc;
    start_row = 5'(sr); start_col = 7'(sc); end_row = 5'(er); end_col = 7'(ec);
    abort = ab; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  // Drives wr_ready/abort during an active fill and logs accepted writes.
  task automatic runFill(input int maxCyc, input bit toggle, input int abortAt,
                         output int nWr, output int doneCnt, output int cyc, output bit timedOut);
    nWr = 0; doneCnt = 0; cyc = 0;
    while (busy && cyc < maxCyc) begin
      wr_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      abort = (abortAt > 0) && (cyc == abortAt - 1);
      cAddr[cyc] = wr_addr;
      cData[cyc] = wr_data;
      if (wr_en && wr_ready) begin
        wAddr[nWr] = wr_addr;
        wData[nWr] = wr_data;
        nWr++;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      if (done) doneCnt++;
      cyc++;
    end
    timedOut = busy;
    wr_ready = 1'b0;
    @(posedge clk); #1;
    if (done) doneCnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({wr_en, busy, done, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {wr_en, busy, done, err});
    end
    total++;
    if (wr_addr !== 12'h000 || wr_data !== 7'h00) begin
      bad++; $display("FAIL reset_addr_data got=%h/%h exp=000/00", wr_addr, wr_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_screen();
    int n, dc, cy, mism;
    bit to;
    request(1'b1, 7'h20, 0, 0, 31, 79, 1'b0);
    total++;
    if (wr_en !== 1'b1 || busy !== 1'b1 || wr_addr !== 12'h000 || wr_data !== 7'h20) begin
      bad++; $display("FAIL full_first got en=%b addr=%h data=%h exp en=1 addr=000 data=20", wr_en, wr_addr, wr_data);
    end
    runFill(3000, 1'b0, 0, n, dc, cy, to);
    total++;
    if (n !== 2560 || cy !== 2560 || to) begin
      bad++; $display("FAIL full_count got writes=%0d cycles=%0d exp 2560/2560", n, cy);
    end
    mism = 0;
    for (int i = 0; i < n && i < 2560; i++) begin
      if (wAddr[i] !== mkAddr(i % 80, i / 80) || wData[i] !== 7'((32 + i) % 128)) mism++;
    end
    total++;
    if (mism != 0) begin
      bad++; $display("FAIL full_sequence got mismatches=%0d exp 0", mism);
    end
    total++;
    if (n > 0 && (wAddr[n-1] !== {7'd79, 5'd31} || wData[n-1] !== 7'h1F)) begin
      bad++; $display("FAIL full_last got addr=%h data=%h exp addr=%h data=1f", wAddr[n-1], wData[n-1], {7'd79, 5'd31});
    end
    total++;
    if (dc !== 1) begin
      bad++; $display("FAIL full_done got done_cycles=%0d exp 1", dc);
    end
  endtask

  task automatic test_partial_row();
    int n, dc, cy, mism;
    bit to;
    request(1'b0, 7'h00, 5, 40, 5, 79, 1'b0);
    runFill(200, 1'b0, 0, n, dc, cy, to);
    mism = 0;
    for (int i = 0; i < n && i < 40; i++) begin
      if (wAddr[i] !== mkAddr(40 + i, 5) || wData[i] !== 7'h00) mism++;
    end
    total++;
    if (n !== 40 || mism != 0 || to) begin
      bad++; $display("FAIL partial_row got writes=%0d mismatches=%0d exp 40/0", n, mism);
    end
    total++;
    if (dc !== 1) begin
      bad++; $display("FAIL partial_done got done_cycles=%0d exp 1", dc);
    end
  endtask

  task automatic test_backpressure();
    int n, dc, cy, held;
    bit to;
    logic [11:0] expA [0:3];
    logic [6:0]  expD [0:3];
    expA[0] = mkAddr(78, 3); expA[1] = mkAddr(79, 3); expA[2] = mkAddr(0, 4); expA[3] = mkAddr(1, 4);
    expD[0] = 7'h7E; expD[1] = 7'h7F; expD[2] = 7'h00; expD[3] = 7'h01;
    request(1'b1, 7'h7E, 3, 78, 4, 1, 1'b0);
    runFill(50, 1'b1, 0, n, dc, cy, to);
    total++;
    if (n !== 4 || cy !== 7 || to) begin
      bad++; $display("FAIL bp_count got writes=%0d cycles=%0d exp 4/7", n, cy);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wAddr[i] !== expA[i] || wData[i] !== expD[i]) begin
        bad++; $display("FAIL bp_write%0d got addr=%h data=%h exp addr=%h data=%h", i, wAddr[i], wData[i], expA[i], expD[i]);
      end
    end
    held = 0;
    for (int k = 0; k < 3; k++) begin
      if (cAddr[2*k+2] !== cAddr[2*k+1] || cData[2*k+2] !== cData[2*k+1]) held++;
    end
    total++;
    if (held != 0) begin
      bad++; $display("FAIL bp_hold got unheld=%0d exp 0", held);
    end
    total++;
    if (dc !== 1) begin
      bad++; $display("FAIL bp_done got done_cycles=%0d exp 1", dc);
    end
  endtask

  task automatic test_invalid();
    int seen, errs;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) request(1'b0, 7'h11, 10, 0, 9, 79, 1'b0);
      else        request(1'b0, 7'h11, 0, 0, 0, 80, 1'b0);
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
        bad++; $display("FAIL invalid%0d_pulse got err=%b busy=%b en=%b exp 1/0/0", t, err, busy, wr_en);
      end
      seen = 0; errs = 0;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if (wr_en || busy) seen++;
        if (err) errs++;
      end
      total++;
      if (seen != 0 || errs != 0) begin
        bad++; $display("FAIL invalid%0d_quiet got active=%0d err_cycles=%0d exp 0/0", t, seen, errs);
      end
    end
  endtask

  task automatic test_single_cell();
    int n, dc, cy;
    bit to;
    request(1'b1, 7'h55, 7, 7, 7, 7, 1'b0);
    runFill(20, 1'b0, 0, n, dc, cy, to);
    total++;
    if (n !== 1 || wAddr[0] !== mkAddr(7, 7) || wData[0] !== 7'h55 || dc !== 1) begin
      bad++; $display("FAIL single_cell got writes=%0d addr=%h data=%h done=%0d exp 1/%h/55/1", n, wAddr[0], wData[0], dc, mkAddr(7, 7));
    end
    total++;
    if (wr_addr !== mkAddr(7, 7) || wr_data !== 7'h55) begin
      bad++; $display("FAIL idle_hold got addr=%h data=%h exp %h/55", wr_addr, wr_data, mkAddr(7, 7));
    end
  endtask

  task automatic test_abort();
    int n, dc, cy;
    bit to;
    request(1'b0, 7'h2A, 0, 0, 1, 79, 1'b0);
    runFill(500, 1'b0, 5, n, dc, cy, to);
    total++;
    if (n !== 5 || cy !== 5 || dc !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort got writes=%0d cycles=%0d done=%0d busy=%b exp 5/5/0/0", n, cy, dc, busy);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle got busy=%b err=%b done=%b exp 0/0/0", busy, err, done);
    end
    request(1'b0, 7'h33, 2, 0, 2, 9, 1'b1);
    runFill(100, 1'b0, 0, n, dc, cy, to);
    total++;
    if (n !== 10 || dc !== 1 || wAddr[9] !== mkAddr(9, 2)) begin
      bad++; $display("FAIL start_with_abort got writes=%0d done=%0d last=%h exp 10/1/%h", n, dc, wAddr[9], mkAddr(9, 2));
    end
  endtask

  task automatic test_restart_and_reset();
    int n, dc, cy, act;
    bit to;
    request(1'b0, 7'h41, 0, 0, 0, 79, 1'b0);
    wr_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    seq = 1'b1; start_row = 5'd5; start_col = 7'd5; end_row = 5'd5; end_col = 7'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (wr_addr !== mkAddr(4, 0) || wr_data !== 7'h41 || err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL start_ignored got addr=%h data=%h err=%b busy=%b exp %h/41/0/1", wr_addr, wr_data, err, busy, mkAddr(4, 0));
    end
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; wr_ready = 1'b0;
    total++;
    if ({wr_en, busy, done, err} !== 4'b0000 || wr_addr !== 12'h000 || wr_data !== 7'h00) begin
      bad++; $display("FAIL mid_reset got flags=%b addr=%h data=%h exp 0000/000/00", {wr_en, busy, done, err}, wr_addr, wr_data);
    end
    act = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy || err) act++;
    end
    total++;
    if (act != 0) begin
      bad++; $display("FAIL post_reset_quiet got active_cycles=%0d exp 0", act);
    end
    request(1'b1, 7'h10, 1, 0, 1, 3, 1'b0);
    runFill(50, 1'b0, 0, n, dc, cy, to);
    total++;
    if (n !== 4 || dc !== 1 || wAddr[3] !== mkAddr(3, 1) || wData[3] !== 7'h13) begin
      bad++; $display("FAIL post_reset_fill got writes=%0d done=%0d last=%h/%h exp 4/1/%h/13", n, dc, wAddr[3], wData[3], mkAddr(3, 1));
    end
  endtask

  initial begin
    test_reset();
    test_full_screen();
    test_partial_row();
    test_backpressure();
    test_invalid();
    test_single_cell();
    test_abort();
    test_restart_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_buffer_fill.md
CHAR_BUFFER_FILL -- requirements
Module: char_buffer_fill

Interface
REQ-001 Parameters SHALL be: COLS, default 80, columns per screen row.
REQ-002 Parameters SHALL be: ROWS, default 32, screen rows.
REQ-003 Parameters SHALL be: COL_W, default 7, column index width.
REQ-004 Parameters SHALL be: ROW_W, default 5, row index width.
REQ-005 Parameters SHALL be: DATA_W, default 7, character code width.
REQ-006 Ports SHALL be: clk  in  1  sole clock; all logic rising-edge.
REQ-007 Ports SHALL be: reset  in  1  synchronous, active-high reset.
REQ-008 Ports SHALL be: start  in  1  one-cycle request pulse.
REQ-009 Ports SHALL be: seq  in  1  0 = constant fill, 1 = incrementing fill.
REQ-010 Ports SHALL be: fill_char  in  DATA_W  constant value, or first value when seq=1.
REQ-011 Ports SHALL be: start_row/start_col  in  ROW_W/COL_W  first cell of region.
REQ-012 Ports SHALL be: end_row/end_col  in  ROW_W/COL_W  last cell of region, inclusive.
REQ-013 Ports SHALL be: abort  in  1  cancel an active fill.
REQ-014 Ports SHALL be: wr_ready  in  1  buffer write port granted this cycle.
REQ-015 Ports SHALL be: wr_en  out  1; wr_addr  out  COL_W+ROW_W  {col,row}; wr_data  out  DATA_W.
REQ-016 Ports SHALL be: busy  out  1; done  out  1  one-cycle completion pulse; err  out  1  one-cycle reject pulse.

Function
REQ-017 States SHALL be IDLE and ACTIVE; busy = (state==ACTIVE); wr_en = busy.
REQ-018 In IDLE, start=1 SHALL register all request inputs; if valid, state becomes ACTIVE next cycle, wr_en high at N+1 for start at N.
REQ-019 A request SHALL be invalid if start_row or end_row >= ROWS, start_col or end_col >= COLS, or (end_row*COLS+end_col) < (start_row*COLS+start_col).
REQ-020 An invalid request SHALL pulse err for one cycle at N+1, perform no writes, and stay in IDLE.
REQ-021 Traversal SHALL be raster order: col increments first; at col COLS-1 it wraps to 0 and row increments.
REQ-022 A write SHALL be accepted when wr_en & wr_ready; cursor and data SHALL advance only on acceptance; otherwise wr_addr/wr_data are held.
REQ-023 wr_data SHALL equal fill_char for every write when seq=0; when seq=1 it starts at fill_char and increments by 1 modulo 2^DATA_W per accepted write.
REQ-024 Total accepted writes SHALL equal (end_row*COLS+end_col)-(start_row*COLS+start_col)+1, each address exactly once.
REQ-025 On acceptance at the end cell, state SHALL go IDLE next cycle with done=1 for exactly that one cycle.
REQ-026 start while ACTIVE SHALL be ignored, with no err.
REQ-027 abort in ACTIVE SHALL return to IDLE next cycle with no done; a write accepted in that same cycle stands.
REQ-028 abort coincident with acceptance of the end cell SHALL take priority: IDLE next cycle, done not pulsed.
REQ-029 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL be treated as start only.
REQ-030 In IDLE, wr_addr and wr_data SHALL hold their last values; no write is issued.

Reset
REQ-031 reset=1 at any clock edge SHALL force state IDLE and wr_en, busy, done, err to 0, and wr_addr, wr_data to 0, overriding all other inputs.
REQ-032 Reset asserted mid-fill SHALL abandon the fill with no done pulse; the first start after reset deasserts SHALL be honoured normally.

Verification
REQ-033 Full screen, seq=1, fill_char=0x20, region (0,0)-(31,79), wr_ready=1 -> 2560 writes on consecutive cycles, last wr_addr {79,31}, last wr_data 0x1F (wrap mod 128), then done one cycle.
REQ-034 Partial row, seq=0, fill_char=0, region (5,40)-(5,79) -> 40 writes with addresses {40,5}..{79,5}, then done.
REQ-035 Region (3,78)-(4,1) with wr_ready toggling 1,0,1,0 -> addresses {78,3},{79,3},{0,4},{1,4}, each held while wr_ready=0, done after 4th acceptance.
REQ-036 Invalid region (10,0)-(9,79), and separately end_col=80 -> err pulse at N+1, wr_en never asserted, busy stays 0.
REQ-037 abort asserted on the 5th cycle of a fill -> exactly 5 accepted writes, IDLE next cycle, no done; a following start runs to completion.
REQ-038 reset asserted mid-fill -> all outputs 0 next cycle; start issued during the fill is ignored, start issued after reset runs to completion.
